if_fetch: RTL

- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and fetches one 32-bit instruction per request from the instruction memory over a req/ack handshake.
- Presents pc/instruction pairs to IF/ID.
- Raises a stall request to ctrl while no instruction is ready, and redirects the PC on a jump from ID.

---
 rtl/if_fetch.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, fetches one word per request over a
// req/ack handshake and presents pc/instruction pairs to the IF/ID register.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          STALL_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               jumpout,
    input  logic [31:0]        jump_addr,
    output logic               mem_req,
    output logic [31:0]        mem_addr,
    input  logic               mem_ack,
    input  logic [31:0]        mem_rdata,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_inst,
    output logic               if_valid,
    output logic               stallreq_if
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        READY = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] req_addr, req_addr_nxt;
    logic [31:0] buf_pc, buf_pc_nxt;
    logic [31:0] buf_inst, buf_inst_nxt;
    logic [31:0] jump_tgt;

    // Only stall[1] and the word part of the jump target steer this stage.
    logic [STALL_W+1:0] unused_in;
    assign unused_in = {stall, jump_addr[1:0]};

    assign jump_tgt = {jump_addr[31:2], 2'b00};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            buf_pc   <= '0;
            buf_inst <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            req_addr <= req_addr_nxt;
            buf_pc   <= buf_pc_nxt;
            buf_inst <= buf_inst_nxt;
        end
    end

    // NOTE: every combinational output is given a default first so no path
    // through the case statement can leave a value unassigned (no latches).
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        req_addr_nxt = req_addr;
        buf_pc_nxt   = buf_pc;
        buf_inst_nxt = buf_inst;

        unique case (state)
            IDLE: begin
                state_nxt = FETCH;
                if (jumpout) begin
                    pc_nxt       = jump_tgt;
                    req_addr_nxt = jump_tgt;
                end else begin
                    req_addr_nxt = pc;
                end
            end

            FETCH: begin
                if (jumpout && mem_ack) begin
                    pc_nxt       = jump_tgt;
                    req_addr_nxt = jump_tgt;
                end else if (jumpout) begin
                    // The request in flight cannot be withdrawn; wait it out.
                    pc_nxt    = jump_tgt;
                    state_nxt = DRAIN;
                end else if (mem_ack) begin
                    buf_inst_nxt = mem_rdata;
                    buf_pc_nxt   = req_addr;
                    pc_nxt       = req_addr + 32'd4;
                    state_nxt    = READY;
                end
            end

            DRAIN: begin
                if (jumpout) begin
                    pc_nxt = jump_tgt;
                end
                if (mem_ack) begin
                    req_addr_nxt = jumpout ? jump_tgt : pc;
                    state_nxt    = FETCH;
                end
            end

            READY: begin
                if (jumpout) begin
                    pc_nxt       = jump_tgt;
                    req_addr_nxt = jump_tgt;
                    state_nxt    = FETCH;
                end else if (!stall[1]) begin
                    req_addr_nxt = pc;
                    state_nxt    = FETCH;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode from registered state only.
    always_comb begin
        mem_req     = 1'b0;
        mem_addr    = req_addr;
        if_valid    = 1'b0;
        if_pc       = '0;
        if_inst     = '0;
        stallreq_if = 1'b1;

        unique case (state)
            FETCH, DRAIN: mem_req = 1'b1;
            READY: begin
                if_valid    = 1'b1;
                if_pc       = buf_pc;
                if_inst     = buf_inst;
                stallreq_if = 1'b0;
            end
            default: ;
        endcase
    end

endmodule
